chip8_rom_loader: RTL and testbench
===================================

CHIP8_ROM_LOADER -- requirements
Module: chip8_rom_loader

Interface
REQ-001 SHALL have parameter LOAD_BASE, default 12'h200, the first CHIP-8 memory address written.
REQ-002 SHALL have parameter READ_LATENCY, default 2, the cycles from read strobe to valid bus_readdata.
REQ-003 SHALL have port clk, input, 1, system clock; reset is synchronous, active-high, on clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle load request.
REQ-006 SHALL have port rom_len, input, 12, byte count sampled on accepted start.
REQ-007 SHALL have ports s_valid (in, 1), s_data (in, 8) and s_ready (out, 1) forming the ROM byte stream.
REQ-008 SHALL have ports bus_chipselect (out, 1), bus_write (out, 1), bus_address (out, 18) and bus_writedata (out, 32) driving the emulator register bus.
REQ-009 SHALL have port bus_readdata, input, 32, emulator read data.
REQ-010 SHALL have ports busy, done and error, each out, 1, for status.

Function
REQ-011 SHALL use FSM states IDLE, PAUSE, LOAD, GAP, SET_PC, RUN and DONE, plus VERIFY_RD and VERIFY_WAIT when the verify feature is enabled.
REQ-012 SHALL in IDLE, on start=1, latch rom_len, clear the offset counter and error, and go to PAUSE; start SHALL be ignored in all other states.
REQ-013 SHALL in PAUSE issue one write with address 18'h16 and writedata 32'h3 (emulator paused), then go to LOAD, or to SET_PC if rom_len is 0.
REQ-014 SHALL in LOAD drive s_ready=1; on s_valid&s_ready it SHALL issue a write with address {1'b0,1'b1,4'h0,LOAD_BASE+offset} and writedata {24'h0,s_data}, increment offset, and go to GAP.
REQ-015 SHALL assert bus_chipselect for exactly one cycle per access, and SHALL insert at least one cycle with chipselect=0 between consecutive accesses (GAP state).
REQ-016 SHALL, from GAP, go to LOAD while offset < rom_len, otherwise to SET_PC.
REQ-017 SHALL in SET_PC write address 18'h14 with data {20'h0,LOAD_BASE}, then in RUN write address 18'h16 with data 32'h0, then go to DONE.
REQ-018 SHALL in DONE pulse done for one cycle, then return to IDLE.
REQ-019 SHALL keep s_ready=0 outside LOAD, and no stream byte SHALL be consumed outside LOAD.
REQ-020 SHALL detect address overflow: if LOAD_BASE+offset would exceed 12'hFFF (13-bit compare), it SHALL set error, write no memory, skip to RUN-less DONE, and leave the emulator paused.
REQ-021 SHALL drive bus_write=0, address=0 and writedata=0 whenever bus_chipselect=0.
REQ-022 SHALL hold busy=1 in every state except IDLE.
REQ-023 SHALL hold error until the next accepted start.

Reset
REQ-024 SHALL, on reset (including mid-load), go to IDLE in the same cycle with all outputs 0 and the counters cleared; partially written memory is not restored.

Configuration
REQ-025 SHALL, when macro CHIP8_LOADER_VERIFY_EN is defined, follow each memory write's GAP with VERIFY_RD (a read strobe: chipselect=1, write=0, same address).
REQ-026 SHALL then wait in VERIFY_WAIT for READ_LATENCY cycles and compare bus_readdata[7:0] with the written byte; on mismatch it SHALL set error and go to DONE without SET_PC/RUN.
REQ-027 SHALL, without CHIP8_LOADER_VERIFY_EN, omit the verify states and logic entirely, so that every byte costs 2 cycles.

Structure
REQ-028 SHALL place the FSM state enum and the bus address constants (REG_PC=18'h14, REG_STATE=18'h16, MEM_SEL bit 16) in the shared Chip8 package, next to the existing enums.
REQ-029 SHALL instantiate one sub-module, chip8_bus_strobe, which formats single-cycle access strobes and enforces the gap.

Verification
REQ-030 SHALL verify a normal load: rom_len=3, bytes A2,F0,13 -> writes 16<=3, 10200<=A2, 10201<=F0, 10202<=13, 14<=200, 16<=0, then done pulses once.
REQ-031 SHALL verify an empty ROM: rom_len=0 -> writes only to 16, 14 and 16; s_ready is never asserted.
REQ-032 SHALL verify backpressure: s_valid low for 10 cycles mid-stream -> no bus access occurs, and the load resumes with the correct next address.
REQ-033 SHALL verify overflow: LOAD_BASE=12'hFFE and rom_len=3 -> writes FFE and FFF, then error=1, no PC/state-run write, and done pulses.
REQ-034 SHALL verify reset mid-load after 2 bytes -> the next cycle shows IDLE, busy=0, chipselect=0, and a new start works normally.
REQ-035 SHALL verify, with CHIP8_LOADER_VERIFY_EN, that a model corrupting readback at 10201 -> error=1, done pulses, and there is no write to 14.

Source files
------------

// File: rtl/chip8_rom_loader_pkg.sv
// Shared Chip8 definitions: loader FSM states, emulator register map and bus request format.
// CHIP8_LOADER_VERIFY_EN adds the readback states to the loader FSM.
package chip8_rom_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      PAUSE,
      LOAD,
      GAP,
      SET_PC,
      RUN,
`ifdef CHIP8_LOADER_VERIFY_EN
      VERIFY_RD,
      VERIFY_WAIT,
`endif
      DONE
   } loader_state_e;

   localparam logic [17:0] REG_PC        = 18'h14;
   localparam logic [17:0] REG_STATE     = 18'h16;
   localparam int          MEM_SEL       = 16;
   localparam logic [31:0] STATE_PAUSED  = 32'h3;
   localparam logic [31:0] STATE_RUNNING = 32'h0;

   typedef struct packed {
      logic        wr;
      logic [17:0] addr;
      logic [31:0] data;
   } bus_req_t;

   // CHIP-8 memory lives in the window selected by MEM_SEL.
   function automatic logic [17:0] mem_addr(input logic [11:0] a);
      logic [17:0] r;
      r = {6'h0, a};
      r[MEM_SEL] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/chip8_rom_loader_bus_strobe.sv
// chip8_bus_strobe: turns a held access request into a single-cycle strobe and keeps
// at least one idle cycle between strobes; bus fields read as zero when idle.
module chip8_bus_strobe
   import chip8_rom_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  bus_req_t    req_info,
   output logic        can_issue,
   output logic        accept,
   output logic        bus_chipselect,
   output logic        bus_write,
   output logic [17:0] bus_address,
   output logic [31:0] bus_writedata
);

   logic last_cs_q, last_cs_d;

   assign can_issue = ~last_cs_q & ~reset;
   assign accept    = req & can_issue;

   always_comb begin
      last_cs_d = accept;
   end

   always_ff @(posedge clk) begin
      if (reset) last_cs_q <= 1'b0;
      else       last_cs_q <= last_cs_d;
   end

   always_comb begin
      bus_chipselect = accept;
      bus_write      = 1'b0;
      bus_address    = '0;
      bus_writedata  = '0;
      if (accept) begin
         bus_write     = req_info.wr;
         bus_address   = req_info.addr;
         bus_writedata = req_info.data;
      end
   end

endmodule

// File: rtl/chip8_rom_loader.sv
// chip8_rom_loader: pauses the emulator, streams a ROM into CHIP-8 memory, sets PC and resumes.
// Define CHIP8_LOADER_VERIFY_EN to read back and check every byte after it is written.
module chip8_rom_loader
   import chip8_rom_loader_pkg::*;
#(
   parameter logic [11:0] LOAD_BASE    = 12'h200,
   parameter int          READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] rom_len,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        bus_chipselect,
   output logic        bus_write,
   output logic [17:0] bus_address,
   output logic [31:0] bus_writedata,
   input  logic [31:0] bus_readdata,
   output logic        busy,
   output logic        done,
   output logic        error
);

   loader_state_e state_q, state_d;
   logic [11:0]   len_q, len_d;
   logic [12:0]   off_q, off_d;
   logic          err_q, err_d;
   logic          req, can_issue, accept;
   bus_req_t      breq;
   logic [11:0]   wr_addr;
   logic          ovf;
   loader_state_e after_st;
   logic          after_err;

`ifdef CHIP8_LOADER_VERIFY_EN
   localparam int VW = $clog2(READ_LATENCY + 1) + 1;
   logic [7:0]    byte_q, byte_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
`else
   logic unused_readdata;
   assign unused_readdata = ^bus_readdata;
`endif

   assign wr_addr = LOAD_BASE + off_q[11:0];
   assign ovf     = ({1'b0, LOAD_BASE} + off_q) > 13'hFFF;

   // Decision taken once the previous byte is fully handled (written, and checked if verifying).
   always_comb begin
      after_err = 1'b0;
      after_st  = SET_PC;
      if (off_q < {1'b0, len_q}) begin
         after_st  = ovf ? DONE : LOAD;
         after_err = ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         off_q   <= '0;
         err_q   <= 1'b0;
`ifdef CHIP8_LOADER_VERIFY_EN
         byte_q  <= '0;
         vcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         off_q   <= off_d;
         err_q   <= err_d;
`ifdef CHIP8_LOADER_VERIFY_EN
         byte_q  <= byte_d;
         vcnt_q  <= vcnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      off_d   = off_q;
      err_d   = err_q;
`ifdef CHIP8_LOADER_VERIFY_EN
      byte_d  = byte_q;
      vcnt_d  = vcnt_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            len_d   = rom_len;
            off_d   = '0;
            err_d   = 1'b0;
            state_d = PAUSE;
         end
         PAUSE:  if (accept) state_d = (len_q == 12'd0) ? SET_PC : LOAD;
         LOAD: if (accept) begin
            off_d   = off_q + 13'd1;
            state_d = GAP;
`ifdef CHIP8_LOADER_VERIFY_EN
            byte_d  = s_data;
`endif
         end
`ifdef CHIP8_LOADER_VERIFY_EN
         GAP: state_d = VERIFY_RD;
         VERIFY_RD: if (accept) begin
            vcnt_d  = '0;
            state_d = VERIFY_WAIT;
         end
         VERIFY_WAIT: begin
            vcnt_d = vcnt_q + 1'b1;
            if (vcnt_q == VW'(READ_LATENCY - 1)) begin
               if (bus_readdata[7:0] != byte_q) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  err_d   = err_q | after_err;
                  state_d = after_st;
               end
            end
         end
`else
         GAP: begin
            err_d   = err_q | after_err;
            state_d = after_st;
         end
`endif
         SET_PC: if (accept) state_d = RUN;
         RUN:    if (accept) state_d = DONE;
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req     = 1'b0;
      breq    = '0;
      s_ready = 1'b0;
      case (state_q)
         PAUSE: begin
            req       = 1'b1;
            breq.wr   = 1'b1;
            breq.addr = REG_STATE;
            breq.data = STATE_PAUSED;
         end
         // A byte is only taken when the strobe can go out in the same cycle.
         LOAD: begin
            s_ready   = can_issue;
            req       = s_valid;
            breq.wr   = 1'b1;
            breq.addr = mem_addr(wr_addr);
            breq.data = {24'h0, s_data};
         end
`ifdef CHIP8_LOADER_VERIFY_EN
         VERIFY_RD: begin
            req       = 1'b1;
            breq.addr = mem_addr(wr_addr - 12'd1);
         end
`endif
         SET_PC: begin
            req       = 1'b1;
            breq.wr   = 1'b1;
            breq.addr = REG_PC;
            breq.data = {20'h0, LOAD_BASE};
         end
         RUN: begin
            req       = 1'b1;
            breq.wr   = 1'b1;
            breq.addr = REG_STATE;
            breq.data = STATE_RUNNING;
         end
         default: ;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign error = err_q;

   chip8_bus_strobe u_strobe (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .req_info      (breq),
      .can_issue     (can_issue),
      .accept        (accept),
      .bus_chipselect(bus_chipselect),
      .bus_write     (bus_write),
      .bus_address   (bus_address),
      .bus_writedata (bus_writedata)
   );

endmodule

// File: tb/tb_chip8_rom_loader.sv
// Bench for chip8_rom_loader: two instances (base 200 and FFE) checked against a list-level model.
`timescale 1ns/1ps
module tb_chip8_rom_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] rom_len;
   logic        start [2];
   logic        s_valid [2];
   logic [7:0]  s_data [2];
   logic        s_ready [2];
   logic        cs [2];
   logic        wr [2];
   logic [17:0] addr [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        busy [2];
   logic        done [2];
   logic        err [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      chip8_rom_loader #(.LOAD_BASE(g == 0 ? 12'h200 : 12'hFFE), .READ_LATENCY(2)) u_dut (
         .clk(clk), .reset(reset), .start(start[g]), .rom_len(rom_len),
         .s_valid(s_valid[g]), .s_data(s_data[g]), .s_ready(s_ready[g]),
         .bus_chipselect(cs[g]), .bus_write(wr[g]), .bus_address(addr[g]),
         .bus_writedata(wdata[g]), .bus_readdata(rdata[g]),
         .busy(busy[g]), .done(done[g]), .error(err[g])
      );
   end

   int n_cmp = 0;
   int n_bad = 0;
   int bases [2] = '{12'h200, 12'hFFE};

   // Bus monitor and emulator memory model; counters only grow, tests take deltas.
   logic [49:0] wq0 [$];
   logic [49:0] wq1 [$];
   int          n_done [2] = '{0, 0};
   int          n_rdy [2]  = '{0, 0};
   int          n_viol [2] = '{0, 0};
   int          n_stall_cs = 0;
   logic        mon_stall = 1'b0;
   logic [17:0] corrupt_addr = '1;
   logic        prev_cs [2] = '{1'b0, 1'b0};
   logic        rd_pend [2] = '{1'b0, 1'b0};
   logic [17:0] rd_addr [2];
   logic [7:0]  mem [2][4096];

   initial begin
      rdata[0] = '0;
      rdata[1] = '0;
   end

   always @(negedge clk) begin
      #2;
      for (int g = 0; g < 2; g++) begin
         if (rd_pend[g]) begin
            rdata[g]   = {24'h0, mem[g][rd_addr[g][11:0]] ^ ((rd_addr[g] == corrupt_addr) ? 8'h5A : 8'h00)};
            rd_pend[g] = 1'b0;
         end
         if (done[g]) n_done[g]++;
         if (s_ready[g]) n_rdy[g]++;
         if (!cs[g] && (wr[g] || addr[g] != '0 || wdata[g] != '0)) n_viol[g]++;
         if (cs[g] && prev_cs[g]) n_viol[g]++;
         if (cs[g] && mon_stall) n_stall_cs++;
         if (cs[g] && wr[g]) begin
            if (g == 0) wq0.push_back({addr[g], wdata[g]});
            else        wq1.push_back({addr[g], wdata[g]});
            if (addr[g][16]) mem[g][addr[g][11:0]] = wdata[g][7:0];
         end
         if (cs[g] && !wr[g]) begin
            rd_pend[g] = 1'b1;
            rd_addr[g] = addr[g];
         end
         prev_cs[g] = cs[g];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [49:0] getw(input int g, input int i);
      if (g == 0) return (i < wq0.size()) ? wq0[i] : '1;
      return (i < wq1.size()) ? wq1[i] : '1;
   endfunction

   // Expected write list: pause, one memory write per in-range byte, then PC and run unless an error.
   function automatic void model(input int base, input int len, input logic [7:0] b[$],
                                 input logic [17:0] bad, output logic [49:0] q[$], output bit e);
      int a;
      q = {};
      e = 1'b0;
      q.push_back({18'h16, 32'h3});
      for (int i = 0; i < len; i++) begin
         a = base + i;
         if (a > 4095) begin
            e = 1'b1;
            break;
         end
         q.push_back({18'h10000 + 18'(a), 24'h0, b[i]});
`ifdef CHIP8_LOADER_VERIFY_EN
         if (18'h10000 + 18'(a) == bad) begin
            e = 1'b1;
            break;
         end
`endif
      end
      if (!e) begin
         q.push_back({18'h14, 20'h0, 12'(base)});
         q.push_back({18'h16, 32'h0});
      end
   endfunction

   task automatic run_load(input int g, input int len, input logic [7:0] b[$],
                           input int stall_after, input bit poke);
      logic [49:0] exp [$];
      bit          exp_err;
      int          w0, d0, r0, v0, s0, idx, cyc, stall_left;
      model(bases[g], len, b, corrupt_addr, exp, exp_err);
      w0 = (g == 0) ? wq0.size() : wq1.size();
      d0 = n_done[g]; r0 = n_rdy[g]; v0 = n_viol[g]; s0 = n_stall_cs;
      idx = 0; cyc = 0; stall_left = 10;
      @(negedge clk);
      rom_len  = 12'(len);
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      rom_len  = 12'($urandom);
      while (busy[g] && cyc < 3000) begin
         start[g] = 1'b0;
         if (stall_after >= 0 && idx == stall_after && stall_left > 0) begin
            s_valid[g] = 1'b0;
            mon_stall  = 1'b1;
            stall_left--;
         end else begin
            mon_stall  = 1'b0;
            s_valid[g] = (idx < len) && ($urandom_range(0, 3) != 0);
            s_data[g]  = (idx < len) ? b[idx] : 8'h00;
         end
         #1;
         if (s_valid[g] && s_ready[g]) begin
            idx++;
            if (poke && idx == 1) begin
               start[g] = 1'b1;
               rom_len  = 12'($urandom);
            end
         end
         @(negedge clk);
         cyc++;
      end
      start[g]   = 1'b0;
      s_valid[g] = 1'b0;
      mon_stall  = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("finish_in_time g%0d len%0d", g, len), 64'(cyc < 3000), 64'd1);
      chk($sformatf("write_count g%0d len%0d", g, len),
          64'(((g == 0) ? wq0.size() : wq1.size()) - w0), 64'(exp.size()));
      foreach (exp[i]) chk($sformatf("write%0d g%0d", i, g), 64'(getw(g, w0 + i)), 64'(exp[i]));
      chk($sformatf("error g%0d len%0d", g, len), 64'(err[g]), 64'(exp_err));
      chk($sformatf("done_pulses g%0d", g), 64'(n_done[g] - d0), 64'd1);
      chk($sformatf("bus_protocol g%0d", g), 64'(n_viol[g] - v0), 64'd0);
      if (len == 0) chk("ready_on_empty", 64'(n_rdy[g] - r0), 64'd0);
      if (stall_after >= 0) chk("access_during_stall", 64'(n_stall_cs - s0), 64'd0);
   endtask

   initial begin
      logic [7:0] b [$];
      int idx, cyc;
      reset = 1'b1;
      rom_len = '0;
      for (int g = 0; g < 2; g++) begin
         start[g] = 1'b0; s_valid[g] = 1'b0; s_data[g] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy[0]), 64'd0);
      chk("rst_done", 64'(done[0]), 64'd0);
      chk("rst_error", 64'(err[0]), 64'd0);
      chk("rst_cs", 64'(cs[0]), 64'd0);
      chk("rst_ready", 64'(s_ready[0]), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      b = '{8'hA2, 8'hF0, 8'h13};
      run_load(0, 3, b, -1, 1'b0);
      b = {};
      run_load(0, 0, b, -1, 1'b0);
      b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      run_load(0, 6, b, 2, 1'b0);

      b = '{8'h01, 8'h02, 8'h03};
      run_load(1, 3, b, -1, 1'b0);
      repeat (5) @(negedge clk);
      chk("error_held", 64'(err[1]), 64'd1);
      b = '{8'h7E};
      run_load(1, 1, b, -1, 1'b0);

      for (int t = 0; t < 6; t++) begin
         int g, len;
         g   = (t % 3 == 2) ? 1 : 0;
         len = (g == 0) ? $urandom_range(1, 12) : $urandom_range(1, 4);
         b = {};
         for (int i = 0; i < len; i++) b.push_back(8'($urandom));
         run_load(g, len, b, -1, t == 1);
      end

      // Reset after two bytes have been written.
      @(negedge clk);
      rom_len = 12'd5; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0; idx = 0; cyc = 0;
      while (idx < 2 && cyc < 200) begin
         s_valid[0] = 1'b1; s_data[0] = 8'($urandom);
         #1;
         if (s_ready[0]) idx++;
         @(negedge clk);
         cyc++;
      end
      chk("two_bytes_before_reset", 64'(idx), 64'd2);
      s_valid[0] = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset_busy", 64'(busy[0]), 64'd0);
      chk("midreset_cs", 64'(cs[0]), 64'd0);
      chk("midreset_ready", 64'(s_ready[0]), 64'd0);
      chk("midreset_done", 64'(done[0]), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_load(0, 4, b, -1, 1'b0);

`ifdef CHIP8_LOADER_VERIFY_EN
      corrupt_addr = 18'h10201;
      b = '{8'hA2, 8'hF0, 8'h13};
      run_load(0, 3, b, -1, 1'b0);
      corrupt_addr = '1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
